// File: rtl/bit_serial_adder_if.sv
// Operand/result bundle for bit_serial_adder; the ovf signal exists only when
// SERIAL_ADD_OVF_EN is defined.
interface bit_serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s_out;
    logic             c_out;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start,
        output x,
        output y,
        output c_in,
        input  busy,
        input  done,
        input  s_out,
`ifdef SERIAL_ADD_OVF_EN
        input  ovf,
`endif
        input  c_out
    );

    modport slave (
        input  start,
        input  x,
        input  y,
        input  c_in,
        output busy,
        output done,
        output s_out,
`ifdef SERIAL_ADD_OVF_EN
        output ovf,
`endif
        output c_out
    );
endinterface

// File: rtl/bit_serial_adder.sv
// LSB-first serial adder: one full_adder cell plus carry and operand shift registers.
// Optional signed-overflow flag enabled by defining SERIAL_ADD_OVF_EN.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module bit_serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    bit_serial_adder_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_c;

    full_adder u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c_in  (carry),
        .s     (fa_s),
        .c_out (fa_c)
    );

    // Control FSM and datapath; outputs only change on the final RUN edge so no partial sums leak.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            sum_sr    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.s_out <= '0;
            bus.c_out <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            bus.ovf   <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr     <= bus.x;
                        b_sr     <= bus.y;
                        carry    <= bus.c_in;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
                    carry  <= fa_c;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        bus.s_out <= {fa_s, sum_sr[WIDTH-1:1]};
                        bus.c_out <= fa_c;
`ifdef SERIAL_ADD_OVF_EN
                        // carry still holds the carry into the MSB on this edge
                        bus.ovf   <= carry ^ fa_c;
`endif
                        bus.busy  <= 1'b0;
                        bus.done  <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: WIDTH=8 directed/random and WIDTH=4 exhaustive.
module tb_bit_serial_adder;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bit_serial_adder_if #(.WIDTH(8)) a8 ();
    bit_serial_adder_if #(.WIDTH(4)) a4 ();

    bit_serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(a8));
    bit_serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(a4));

    // Launch one WIDTH=8 operation, scramble inputs after acceptance, wait (bounded) for done.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        output logic [7:0] s, output logic co, output int lat,
                        output int busy_cyc, output logic done_after);
        @(negedge clk);
        a8.x = a; a8.y = b; a8.c_in = ci; a8.start = 1'b1;
        @(posedge clk); #1;
        a8.start = 1'b0;
        a8.x = 8'($urandom); a8.y = 8'($urandom); a8.c_in = 1'($urandom);
        lat = 0; busy_cyc = 0;
        while (a8.done !== 1'b1 && lat < 40) begin
            if (a8.busy === 1'b1) busy_cyc++;
            @(posedge clk); #1;
            lat++;
        end
        s = a8.s_out; co = a8.c_out;
        @(posedge clk); #1;
        done_after = a8.done;
        @(posedge clk); #1;
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic ci,
                        output logic [3:0] s, output logic co, output int lat);
        @(negedge clk);
        a4.x = a; a4.y = b; a4.c_in = ci; a4.start = 1'b1;
        @(posedge clk); #1;
        a4.start = 1'b0;
        a4.x = 4'($urandom); a4.y = 4'($urandom);
        lat = 0;
        while (a4.done !== 1'b1 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        s = a4.s_out; co = a4.c_out;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a8.start = 1'b0; a8.x = '0; a8.y = '0; a8.c_in = 1'b0;
        a4.start = 1'b0; a4.x = '0; a4.y = '0; a4.c_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a8.busy, a8.done, a8.c_out, a8.s_out} !== 11'h0) begin
            errors++;
            $display("FAIL reset_w8: busy=%b done=%b c=%b s=%h, want all 0", a8.busy, a8.done, a8.c_out, a8.s_out);
        end
        checks++;
        if ({a4.busy, a4.done, a4.c_out, a4.s_out} !== 7'h0) begin
            errors++;
            $display("FAIL reset_w4: busy=%b done=%b c=%b s=%h, want all 0", a4.busy, a4.done, a4.c_out, a4.s_out);
        end
`ifdef SERIAL_ADD_OVF_EN
        checks++;
        if (a8.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", a8.ovf); end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] s; logic co, da; int lat, bc;
        run8(8'hFF, 8'h01, 1'b0, s, co, lat, bc, da);
        checks++;
        if ({co, s} !== 9'h100) begin errors++; $display("FAIL basic_sum: got c=%b s=%h want c=1 s=00", co, s); end
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", lat); end
        checks++;
        if (bc !== 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 8", bc); end
        checks++;
        if (da !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: done still %b next cycle, want 0", da); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s; logic co, da; int lat, bc;
        run8(8'h5A, 8'hA5, 1'b1, s, co, lat, bc, da);
        checks++;
        if ({co, s} !== 9'h100 || lat !== 8 || da !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: c=%b s=%h lat=%0d done_next=%b want c=1 s=00 lat=8 done_next=0", co, s, lat, da);
        end
        run8(8'h00, 8'h00, 1'b0, s, co, lat, bc, da);
        checks++;
        if ({co, s} !== 9'h000 || lat !== 8 || da !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: c=%b s=%h lat=%0d done_next=%b want c=0 s=00 lat=8 done_next=0", co, s, lat, da);
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        @(negedge clk);
        a8.x = 8'h10; a8.y = 8'h20; a8.c_in = 1'b0; a8.start = 1'b1;
        @(posedge clk); #1;
        a8.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a8.x = 8'hFF; a8.y = 8'hFF; a8.start = 1'b1;
        @(posedge clk); #1;
        a8.start = 1'b0;
        lat = 0;
        while (a8.done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (a8.done !== 1'b1 || {a8.c_out, a8.s_out} !== 9'h030) begin
            errors++;
            $display("FAIL ignore_start_result: done=%b c=%b s=%h want done=1 c=0 s=30", a8.done, a8.c_out, a8.s_out);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (a8.busy !== 1'b0 || a8.done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_not_queued: busy=%b done=%b want 0 0", a8.busy, a8.done);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] s; logic co, da; int lat, bc;
        @(negedge clk);
        a8.x = 8'h37; a8.y = 8'h11; a8.c_in = 1'b1; a8.start = 1'b1;
        @(posedge clk); #1;
        a8.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({a8.busy, a8.done, a8.c_out, a8.s_out} !== 11'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b c=%b s=%h want all 0", a8.busy, a8.done, a8.c_out, a8.s_out);
        end
`ifdef SERIAL_ADD_OVF_EN
        checks++;
        if (a8.ovf !== 1'b0) begin errors++; $display("FAIL reset_mid_ovf: got %b want 0", a8.ovf); end
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (a8.busy !== 1'b0 || a8.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle: busy=%b done=%b want 0 0", a8.busy, a8.done);
        end
        run8(8'h03, 8'h04, 1'b0, s, co, lat, bc, da);
        checks++;
        if ({co, s} !== 9'h007 || lat !== 8) begin
            errors++;
            $display("FAIL reset_mid_next_op: c=%b s=%h lat=%0d want c=0 s=07 lat=8", co, s, lat);
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b, s; logic ci, co, da; logic [8:0] exp; int lat, bc;
        for (int i = 0; i < 30; i++) begin
            a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
            exp = 9'(a) + 9'(b) + 9'(ci);
            run8(a, b, ci, s, co, lat, bc, da);
            checks++;
            if ({co, s} !== exp || lat !== 8) begin
                errors++;
                $display("FAIL random_w8 %h+%h+%b: got c=%b s=%h lat=%0d want %h lat=8", a, b, ci, co, s, lat, exp);
            end
`ifdef SERIAL_ADD_OVF_EN
            checks++;
            if (a8.ovf !== ((a[7] == b[7]) && (exp[7] != a[7]))) begin
                errors++;
                $display("FAIL random_ovf %h+%h+%b: got %b want %b", a, b, ci, a8.ovf, (a[7] == b[7]) && (exp[7] != a[7]));
            end
`endif
        end
    endtask

    task automatic test_exhaustive_w4();
        logic [3:0] a, b, s; logic ci, co; logic [4:0] exp; int lat;
        for (int i = 0; i < 512; i++) begin
            a = 4'(i); b = 4'(i >> 4); ci = 1'(i >> 8);
            exp = 5'(a) + 5'(b) + 5'(ci);
            run4(a, b, ci, s, co, lat);
            checks++;
            if ({co, s} !== exp || lat !== 4) begin
                errors++;
                $display("FAIL exhaustive_w4 %h+%h+%b: got c=%b s=%h lat=%0d want %h lat=4", a, b, ci, co, s, lat, exp);
            end
        end
    endtask

`ifdef SERIAL_ADD_OVF_EN
    task automatic test_ovf();
        logic [7:0] s; logic co, da; int lat, bc;
        run8(8'h7F, 8'h01, 1'b0, s, co, lat, bc, da);
        checks++;
        if (a8.ovf !== 1'b1 || s !== 8'h80) begin
            errors++;
            $display("FAIL ovf_pos: ovf=%b s=%h want ovf=1 s=80", a8.ovf, s);
        end
        run8(8'hFF, 8'h01, 1'b0, s, co, lat, bc, da);
        checks++;
        if (a8.ovf !== 1'b0) begin errors++; $display("FAIL ovf_none: ovf=%b want 0", a8.ovf); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        test_random();
        test_exhaustive_w4();
`ifdef SERIAL_ADD_OVF_EN
        test_ovf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
